// File: rtl/version_stream_if.sv
// Byte-stream valid/ready link carrying framed build-identity records.
// The master drives data/valid/last and the slave returns ready.
interface version_stream_if;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/version_streamer.sv
// Build-identity reporter: snapshots info_i on request and streams SYNC, LEN, payload (MSB first).
// Optional trailing checksum byte is enabled by defining VERSION_STREAM_CSUM_EN.
module version_streamer #(
    parameter int         INFO_BYTES = 11,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INFO_BYTES*8-1:0] info_i,
    input  logic                    req_i,
    output logic                    busy_o,
    version_stream_if.master        m,
    output logic [CNT_W-1:0]        frame_cnt_o
);

    localparam int         IDX_W    = (INFO_BYTES > 1) ? $clog2(INFO_BYTES) : 1;
    localparam logic [7:0] LEN_BYTE = 8'(INFO_BYTES);
`ifdef VERSION_STREAM_CSUM_EN
    localparam bit         CSUM_EN  = 1'b1;
`else
    localparam bit         CSUM_EN  = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SYNC, LEN, PAY, CSUM} state_t;

    state_t                  state_reg;
    logic [INFO_BYTES*8-1:0] snap_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic                    pending_reg;
    logic                    busy_reg;
    logic [7:0]              data_reg;
    logic                    valid_reg;
    logic                    last_reg;
    logic [CNT_W-1:0]        cnt_reg;
`ifdef VERSION_STREAM_CSUM_EN
    logic [7:0]              sum_reg;
`endif

    logic [7:0] snap_bytes [INFO_BYTES];
    logic       hs;
    logic       last_hs;

    generate
        for (genvar gi = 0; gi < INFO_BYTES; gi++) begin : g_snap_bytes
            assign snap_bytes[gi] = snap_reg[gi*8 +: 8];
        end
    endgenerate

    assign hs      = valid_reg && m.ready;
    assign last_hs = hs && last_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            snap_reg    <= '0;
            idx_reg     <= '0;
            pending_reg <= 1'b0;
            busy_reg    <= 1'b0;
            data_reg    <= 8'h00;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
            cnt_reg     <= '0;
`ifdef VERSION_STREAM_CSUM_EN
            sum_reg     <= 8'h00;
`endif
        end else begin
            // One-deep request memory; a request on the closing handshake is served directly below.
            if (req_i && state_reg != IDLE && !last_hs)
                pending_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    busy_reg <= req_i;
                    if (req_i) begin
                        snap_reg  <= info_i;
                        state_reg <= SYNC;
                        data_reg  <= SYNC_BYTE;
                        valid_reg <= 1'b1;
                        last_reg  <= 1'b0;
                    end
                end
                SYNC: begin
`ifdef VERSION_STREAM_CSUM_EN
                    sum_reg <= 8'h00;
`endif
                    if (hs) begin
                        state_reg <= LEN;
                        data_reg  <= LEN_BYTE;
                    end
                end
                LEN: begin
                    if (hs) begin
`ifdef VERSION_STREAM_CSUM_EN
                        sum_reg <= sum_reg + data_reg;
`endif
                        state_reg <= PAY;
                        idx_reg   <= IDX_W'(INFO_BYTES - 1);
                        data_reg  <= snap_bytes[INFO_BYTES-1];
                        last_reg  <= !CSUM_EN && (INFO_BYTES == 1);
                    end
                end
                PAY: begin
                    if (hs) begin
`ifdef VERSION_STREAM_CSUM_EN
                        sum_reg <= sum_reg + data_reg;
`endif
                        if (idx_reg == '0) begin
`ifdef VERSION_STREAM_CSUM_EN
                            state_reg <= CSUM;
                            data_reg  <= 8'h00 - (sum_reg + data_reg);
                            last_reg  <= 1'b1;
`endif
                        end else begin
                            idx_reg  <= idx_reg - 1'b1;
                            data_reg <= snap_bytes[idx_reg - 1'b1];
                            last_reg <= !CSUM_EN && (idx_reg == IDX_W'(1));
                        end
                    end
                end
                CSUM: begin
                    // Completion is handled by the last-byte handshake path below.
                end
                default: state_reg <= IDLE;
            endcase

            // Frame completion overrides the per-state updates above.
            if (last_hs) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (pending_reg || req_i) begin
                    pending_reg <= 1'b0;
                    snap_reg    <= info_i;
                    state_reg   <= SYNC;
                    data_reg    <= SYNC_BYTE;
                    valid_reg   <= 1'b1;
                    last_reg    <= 1'b0;
                end else begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                end
            end
        end
    end

    assign m.data      = data_reg;
    assign m.valid     = valid_reg;
    assign m.last      = last_reg;
    assign busy_o      = busy_reg;
    assign frame_cnt_o = cnt_reg;

endmodule

// File: tb/tb_version_streamer.sv
// Directed bench for version_streamer: a frame-level model checked every cycle plus literal pins.
// Define VERSION_STREAM_CSUM_EN for both bench and RTL to exercise the checksum build.
module tb_version_streamer;

    localparam int IB    = 11;
    localparam int CNT_W = 2;
`ifdef VERSION_STREAM_CSUM_EN
    localparam int FL = IB + 3;
`else
    localparam int FL = IB + 2;
`endif

    typedef bit [7:0] bq_t [$];

    localparam logic [IB*8-1:0] INFO_A = 88'h00_00_00_4C_2026_01_14_11_20_43;
    localparam logic [IB*8-1:0] INFO_B = 88'h01_02_03_04_05_06_07_08_09_0A_0B;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req = 1'b0;
    logic             ready = 1'b0;
    logic [IB*8-1:0]  info = '0;
    logic             busy;
    logic [CNT_W-1:0] cnt;

    version_stream_if vif ();
    assign vif.ready = ready;

    version_streamer #(
        .INFO_BYTES (IB),
        .SYNC_BYTE  (8'hA5),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .info_i      (info),
        .req_i       (req),
        .busy_o      (busy),
        .m           (vif),
        .frame_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bq_t build_frame(input logic [IB*8-1:0] inf);
        bq_t q;
        int  s;
        q.push_back(8'hA5);
        q.push_back(8'(IB));
        s = IB;
        for (int i = IB - 1; i >= 0; i--) begin
            q.push_back(inf[i*8 +: 8]);
            s += int'(inf[i*8 +: 8]);
        end
`ifdef VERSION_STREAM_CSUM_EN
        q.push_back(8'((256 - (s % 256)) % 256));
`endif
        return q;
    endfunction

    function automatic bq_t lit_frame_a();
        bq_t q;
        q = '{8'hA5, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h4C, 8'h20, 8'h26,
              8'h01, 8'h14, 8'h11, 8'h20, 8'h43};
`ifdef VERSION_STREAM_CSUM_EN
        q.push_back(8'hDA);
`endif
        return q;
    endfunction

    // Frame-level model state
    bit  m_ok = 1'b0;
    bit  m_in, m_pend, m_busy, m_done, m_nxt;
    int  m_pos, m_cnt;
    bq_t m_frame;
    bq_t log_q;

    always @(negedge clk) begin
        if (m_ok) begin
            chk("valid", int'(vif.valid), int'(m_in));
            if (m_in) begin
                chk("data", int'(vif.data), int'(m_frame[m_pos]));
                chk("last", int'(vif.last), int'(m_pos == FL - 1));
            end
            chk("busy", int'(busy), int'(m_busy));
            chk("frame_cnt", int'(cnt), m_cnt);
        end
        if (!rst && vif.valid === 1'b1 && ready)
            log_q.push_back(vif.data);
        if (rst) begin
            m_ok = 1'b1; m_in = 1'b0; m_pend = 1'b0; m_busy = 1'b0;
            m_pos = 0; m_cnt = 0;
        end else if (m_ok) begin
            m_done = m_in && ready && (m_pos == FL - 1);
            m_nxt  = m_in;
            if (!m_in) begin
                if (req) begin
                    m_frame = build_frame(info); m_pos = 0; m_nxt = 1'b1;
                end
            end else if (m_done) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (m_pend || req) begin
                    m_frame = build_frame(info); m_pos = 0; m_pend = 1'b0;
                end else begin
                    m_nxt = 1'b0;
                end
            end else begin
                if (ready) m_pos++;
                if (req) m_pend = 1'b1;
            end
            m_busy = m_nxt || m_done;
            m_in   = m_nxt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int b = 0;
        while (log_q.size() < n && b < 500) begin tick(); b++; end
        if (log_q.size() < n) chk("timeout_log", log_q.size(), n);
    endtask

    task automatic wait_idle();
        int b = 0;
        while (busy !== 1'b0 && b < 1000) begin tick(); b++; end
        if (busy !== 1'b0) chk("timeout_idle", int'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        log_q.delete();
        chk("rst_valid", int'(vif.valid), 0);
        chk("rst_last", int'(vif.last), 0);
        chk("rst_data", int'(vif.data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(cnt), 0);
    endtask

    task automatic cmp_log(input string name, input bq_t exp, input int off, input int n);
        for (int i = 0; i < n; i++)
            chk(name, int'(log_q[off+i]), int'(exp[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t lit, fb;
        bit  stall;
        logic [7:0] held;
        int  cyc;
        int  wrap_exp [4] = '{1, 2, 3, 0};

        lit = lit_frame_a();
        fb  = build_frame(INFO_A);
        chk("model_len", fb.size(), FL);
        for (int i = 0; i < FL; i++) chk("model_pin", int'(fb[i]), int'(lit[i]));

        // Basic frame with latency pin
        do_reset();
        ready = 1'b1; info = INFO_A;
        pulse_req();
        chk("lat_valid", int'(vif.valid), 1);
        chk("lat_data", int'(vif.data), 8'hA5);
        wait_idle();
        chk("basic_size", log_q.size(), FL);
        cmp_log("basic_byte", lit, 0, FL);
        chk("basic_cnt", int'(cnt), 1);
        $display("txn basic: %0d bytes, frame_cnt=%0d", log_q.size(), cnt);

        // Backpressure with ready pattern 1,0,0,1
        do_reset();
        info = INFO_A; ready = 1'b1;
        pulse_req();
        cyc = 0;
        while (busy === 1'b1 && cyc < 400) begin
            ready = (cyc % 4 == 0 || cyc % 4 == 3);
            stall = vif.valid && !ready;
            held  = vif.data;
            tick();
            if (stall) chk("stall_stable", int'(vif.data), int'(held));
            cyc++;
        end
        ready = 1'b1;
        wait_idle();
        chk("bp_size", log_q.size(), FL);
        cmp_log("bp_byte", lit, 0, FL);
        chk("bp_cnt", int'(cnt), 1);
        $display("txn backpressure: %0d bytes in %0d cycles", log_q.size(), cyc);

        // Pending: start, byte 5, byte 7 -> two frames back-to-back
        do_reset();
        info = INFO_A; ready = 1'b1;
        pulse_req();
        wait_log(5);
        pulse_req();
        wait_log(7);
        pulse_req();
        wait_idle();
        chk("pend_size", log_q.size(), 2 * FL);
        cmp_log("pend_f0", lit, 0, FL);
        cmp_log("pend_f1", lit, FL, FL);
        chk("pend_cnt", int'(cnt), 2);
        $display("txn pending: %0d bytes, frame_cnt=%0d", log_q.size(), cnt);

        // Snapshot isolation, then reset mid-frame
        do_reset();
        info = INFO_A; ready = 1'b1;
        pulse_req();
        wait_log(3);
        info = INFO_B;
        wait_idle();
        cmp_log("iso_f0", lit, 0, FL);
        pulse_req();
        wait_log(FL + 6);
        fb = build_frame(INFO_B);
        cmp_log("iso_f1", fb, FL, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", int'(vif.valid), 0);
        chk("abort_cnt", int'(cnt), 0);
        chk("abort_busy", int'(busy), 0);
        $display("txn isolation+reset: frame_cnt=%0d busy=%0d", cnt, busy);

        // Counter wrap with CNT_W=2
        do_reset();
        info = INFO_B; ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pulse_req();
            wait_idle();
            chk("wrap_cnt", int'(cnt), wrap_exp[k]);
            $display("txn wrap %0d: frame_cnt=%0d", k, cnt);
        end

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
